// File: rtl/hex_cmd_parser.sv
// Assembles ASCII hex digit strings into binary words, emitted one cycle after the terminator byte.
// The completed word is held until out_ready; bytes arriving while it is unaccepted are dropped.
module hex_cmd_parser #(
    parameter  int DATA_W = 16,
    localparam int ND     = DATA_W / 4,
    localparam int CW     = $clog2(ND + 1)
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_ndigits,
    output logic              err,
    output logic              drop
);

    typedef enum logic [1:0] {IDLE, ACCUM, DISCARD, HOLD} state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_acc, w_acc_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_out_valid, w_vld_nxt;
    logic [DATA_W-1:0] r_out_data, w_dat_nxt;
    logic [CW-1:0]     r_out_nd, w_nd_nxt;
    logic              r_err, w_err_nxt;
    logic              r_drop, w_drop_nxt;

    logic              w_is_digit;
    logic              w_is_term;
    logic [3:0]        w_nib;
    logic              w_take;

    always_comb begin
        w_is_digit = 1'b0;
        w_nib      = 4'd0;
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
            w_is_digit = 1'b1;
            w_nib      = in_data[3:0];
        end else if ((in_data >= 8'h41 && in_data <= 8'h46) ||
                     (in_data >= 8'h61 && in_data <= 8'h66)) begin
            w_is_digit = 1'b1;
            w_nib      = in_data[3:0] + 4'd9;
        end
        w_is_term = (in_data == 8'h0D) || (in_data == 8'h0A) ||
                    (in_data == 8'h20) || (in_data == 8'h2C);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_vld_nxt   = r_out_valid;
        w_dat_nxt   = r_out_data;
        w_nd_nxt    = r_out_nd;
        w_err_nxt   = 1'b0;
        w_drop_nxt  = 1'b0;
        w_take      = 1'b0;

        case (r_state)
            IDLE: w_take = in_valid;
            ACCUM: begin
                if (in_valid) begin
                    if (w_is_digit && r_cnt != CW'(ND)) begin
                        w_acc_nxt = {r_acc[DATA_W-5:0], w_nib};
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else if (w_is_term) begin
                        w_dat_nxt   = r_acc;
                        w_nd_nxt    = r_cnt;
                        w_vld_nxt   = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = HOLD;
                    end else begin
                        // Overflowing digit and bad char both kill the token.
                        w_err_nxt   = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (in_valid && w_is_term)
                    w_state_nxt = IDLE;
            end
            HOLD: begin
                if (out_ready) begin
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                    w_take      = in_valid;
                end else if (in_valid) begin
                    w_drop_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Byte handling shared by IDLE and a HOLD cycle that is being accepted.
        if (w_take) begin
            if (w_is_digit) begin
                w_acc_nxt   = {{(DATA_W-4){1'b0}}, w_nib};
                w_cnt_nxt   = CW'(1);
                w_state_nxt = ACCUM;
            end else if (w_is_term) begin
                w_state_nxt = IDLE;
            end else begin
                w_err_nxt   = 1'b1;
                w_state_nxt = DISCARD;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_nd    <= '0;
            r_err       <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_vld_nxt;
            r_out_data  <= w_dat_nxt;
            r_out_nd    <= w_nd_nxt;
            r_err       <= w_err_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_ndigits = r_out_nd;
    assign err         = r_err;
    assign drop        = r_drop;

endmodule

// File: tb/tb_hex_cmd_parser.sv
// Directed-vector bench for hex_cmd_parser; expected words go into a queue that a negedge monitor drains.
module tb_hex_cmd_parser;

    localparam int DATA_W = 16;
    localparam int CW     = 3;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CW-1:0]     n;
    } exp_t;

    logic              CLK = 1'b0;
    logic              resetn;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     out_ndigits;
    logic              err;
    logic              drop;

    exp_t exp_q[$];
    exp_t e_pop;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_err    = 0;
    int   n_drop   = 0;

    hex_cmd_parser #(.DATA_W(DATA_W)) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ndigits(out_ndigits),
        .err        (err),
        .drop       (drop)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: counts pulses and scores every accepted word against the queue.
    always @(negedge CLK) begin
        if (resetn) begin
            if (err)  n_err++;
            if (drop) n_drop++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got data 0x%0h nd %0d, expected no word",
                             out_data, out_ndigits);
                end else begin
                    e_pop = exp_q.pop_front();
                    chk("word_data", 32'(out_data), 32'(e_pop.d));
                    chk("word_ndigits", 32'(out_ndigits), 32'(e_pop.n));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic expect_word(input logic [DATA_W-1:0] d, input logic [CW-1:0] n);
        exp_t e;
        e.d = d;
        e.n = n;
        exp_q.push_back(e);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_out_ndigits"}, 32'(out_ndigits), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_drop"}, 32'(drop), 32'd0);
    endtask

    int e0, d0;

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        idle(2);
        chk_outputs_zero("reset");
        resetn = 1'b1;
        idle(1);

        // 1: "1A\r", word visible exactly one cycle
        e0 = n_err;
        expect_word(16'h001A, 3'd2);
        send_str("1A");
        send(8'h0D);
        chk("t1_valid_hi", 32'(out_valid), 32'd1);
        idle(1);
        chk("t1_valid_lo", 32'(out_valid), 32'd0);
        idle(1);
        chk("t1_err", 32'(n_err - e0), 32'd0);

        // 2: back-to-back tokens, second digit arrives during the accepted hold cycle
        expect_word(16'hFFFF, 3'd4);
        expect_word(16'h0000, 3'd1);
        send_str("ffff 0,");
        idle(2);

        // 3: five digits overflow; next token still parsed
        e0 = n_err;
        expect_word(16'h0007, 3'd1);
        send_str("12345");
        idle(1);
        chk("t3_err_on_5", 32'(n_err - e0), 32'd1);
        send(8'h0D);
        send(8'h37);
        send(8'h0A);
        idle(2);
        chk("t3_err_total", 32'(n_err - e0), 32'd1);

        // 4: bad first char, then bare terminators, then a word proves IDLE
        e0 = n_err;
        send_str("G1");
        send(8'h0D);
        idle(1);
        chk("t4_err_G", 32'(n_err - e0), 32'd1);
        send(8'h0D);
        send(8'h0A);
        send_str("  ");
        idle(1);
        chk("t4_term_only_err", 32'(n_err - e0), 32'd1);
        expect_word(16'h0003, 3'd1);
        send_str("3,");
        idle(2);

        // "0x" prefix is rejected
        e0 = n_err;
        send_str("0x12 ");
        idle(2);
        chk("t7_0x_err", 32'(n_err - e0), 32'd1);

        // 5: backpressure: held word stable, bytes dropped
        d0 = n_drop;
        out_ready = 1'b0;
        expect_word(16'hBEEF, 3'd4);
        send_str("BEEF");
        send(8'h0D);
        send(8'h39);
        send(8'h0D);
        idle(3);
        chk("t5_hold_valid", 32'(out_valid), 32'd1);
        chk("t5_hold_data", 32'(out_data), 32'hBEEF);
        chk("t5_drops", 32'(n_drop - d0), 32'd2);
        out_ready = 1'b1;
        idle(1);
        chk("t5_valid_fell", 32'(out_valid), 32'd0);
        idle(2);
        chk("t5_no_more_drops", 32'(n_drop - d0), 32'd2);

        // 6: reset mid-token discards the partial word
        send_str("AB");
        resetn = 1'b0;
        idle(1);
        chk_outputs_zero("t6_reset");
        resetn = 1'b1;
        expect_word(16'h000C, 3'd1);
        send(8'h43);
        send(8'h0D);
        idle(3);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
